// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the IF/ID, ID/EX and EX/MEM registers of the RV32 core.
// Handles load-use bubbles, branch flushes and memory stalls with timeout.
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 16,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             ifid_use_rs1,
  input  logic             ifid_use_rs2,
  input  logic [6:0]       idex_opcode,
  input  logic [4:0]       idex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_flag,
  output logic             idex_flag,
  output logic             exmem_flag,
  output logic             pc_replace,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             mem_err
);

  typedef enum logic [1:0] {
    S_RUN,
    S_MEM_WAIT,
    S_FLUSH
  } state_t;

  localparam int FW = $clog2(FLUSH_CYCLES) + 1;
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [FW-1:0] FRELOAD = FW'(FLUSH_CYCLES - 1);
  localparam logic [WW-1:0] TMO = WW'(MEM_TIMEOUT);
  localparam logic LONG_FLUSH = (FLUSH_CYCLES > 1);
  localparam logic [6:0] OP_LOAD = 7'b0000011;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [FW-1:0]   r_flush_cnt;
  logic [FW-1:0]   w_flush_nxt;
  logic [WW-1:0]   r_wait_cnt;
  logic [WW-1:0]   w_wait_nxt;
  logic            r_pend_br;
  logic            w_pend_nxt;
  logic [CNT_W-1:0] r_stall;
  logic            r_mem_err;
  logic            w_err_set;

  logic w_load_use;
  logic w_mem_stall;
  logic w_timeout;
  logic w_kill_rel;
  logic w_pc_en;
  logic w_ifid;
  logic w_idex;
  logic w_exmem;
  logic w_kill;

  assign w_load_use = (idex_opcode == OP_LOAD) && (idex_rd != 5'd0) &&
    ((ifid_use_rs1 && (ifid_rs1 == idex_rd)) ||
     (ifid_use_rs2 && (ifid_rs2 == idex_rd)));
  assign w_mem_stall = mem_req && !mem_ready;
  assign w_timeout   = (r_wait_cnt == TMO) && !mem_ready;
  assign w_kill_rel  = r_pend_br || ex_branch_taken;

  always_comb begin
    w_state_nxt = r_state;
    w_flush_nxt = r_flush_cnt;
    w_wait_nxt  = r_wait_cnt;
    w_pend_nxt  = r_pend_br;
    w_err_set   = 1'b0;
    w_pc_en     = 1'b0;
    w_ifid      = 1'b0;
    w_idex      = 1'b0;
    w_exmem     = 1'b0;
    w_kill      = 1'b0;
    unique case (r_state)
      S_RUN: begin
        if (w_mem_stall) begin
          w_state_nxt = S_MEM_WAIT;
          w_wait_nxt  = WW'(1);
          w_pend_nxt  = ex_branch_taken;
        end else if (ex_branch_taken) begin
          {w_pc_en, w_ifid, w_idex, w_exmem, w_kill} = 5'b11111;
          if (LONG_FLUSH) begin
            w_state_nxt = S_FLUSH;
            w_flush_nxt = FRELOAD;
          end
        end else if (w_load_use) begin
          {w_pc_en, w_ifid, w_idex, w_exmem, w_kill} = 5'b00111;
        end else begin
          {w_pc_en, w_ifid, w_idex, w_exmem, w_kill} = 5'b11110;
        end
      end
      S_MEM_WAIT: begin
        if (mem_ready || w_timeout) begin
          // Timeout aborts the access and releases as if it completed.
          {w_pc_en, w_ifid, w_idex, w_exmem} = 4'b1111;
          w_kill     = w_kill_rel;
          w_err_set  = w_timeout;
          w_pend_nxt = 1'b0;
          w_wait_nxt = '0;
          if (w_kill_rel && LONG_FLUSH) begin
            w_state_nxt = S_FLUSH;
            w_flush_nxt = FRELOAD;
          end else begin
            w_state_nxt = S_RUN;
          end
        end else begin
          w_pend_nxt = r_pend_br || ex_branch_taken;
          w_wait_nxt = r_wait_cnt + WW'(1);
        end
      end
      S_FLUSH: begin
        if (w_mem_stall) begin
          w_state_nxt = S_MEM_WAIT;
          w_wait_nxt  = WW'(1);
          w_pend_nxt  = 1'b1;
        end else begin
          {w_pc_en, w_ifid, w_idex, w_exmem, w_kill} = 5'b11111;
          if (ex_branch_taken) begin
            w_flush_nxt = FRELOAD;
          end else if (r_flush_cnt <= FW'(1)) begin
            w_state_nxt = S_RUN;
            w_flush_nxt = '0;
          end else begin
            w_flush_nxt = r_flush_cnt - FW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
    if (reset) begin
      {w_pc_en, w_ifid, w_idex, w_exmem, w_kill} = 5'b01111;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_RUN;
      r_flush_cnt <= '0;
      r_wait_cnt  <= '0;
      r_pend_br   <= 1'b0;
      r_stall     <= '0;
      r_mem_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_pend_br   <= w_pend_nxt;
      if (w_err_set) begin
        r_mem_err <= 1'b1;
      end
      if (!w_pc_en && (r_stall != '1)) begin
        r_stall <= r_stall + CNT_W'(1);
      end
    end
  end

  assign pc_en        = w_pc_en;
  assign ifid_flag    = w_ifid;
  assign idex_flag    = w_idex;
  assign exmem_flag   = w_exmem;
  assign pc_replace   = w_kill;
  assign stall_cycles = r_stall;
  assign mem_err      = r_mem_err;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl.
// Outputs packed as {pc_en, ifid, idex, exmem, pc_replace}.
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  ifid_rs1;
  logic [4:0]  ifid_rs2;
  logic        ifid_use_rs1;
  logic        ifid_use_rs2;
  logic [6:0]  idex_opcode;
  logic [4:0]  idex_rd;
  logic        ex_branch_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_en;
  logic        ifid_flag;
  logic        idex_flag;
  logic        exmem_flag;
  logic        pc_replace;
  logic [31:0] stall_cycles;
  logic        mem_err;
  logic [4:0]  outs;

  int n_total;
  int n_bad;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_ADD = 7'b0110011;

  pipeline_hazard_ctrl #(
    .FLUSH_CYCLES(2),
    .MEM_TIMEOUT (16),
    .CNT_W       (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ifid_rs1       (ifid_rs1),
    .ifid_rs2       (ifid_rs2),
    .ifid_use_rs1   (ifid_use_rs1),
    .ifid_use_rs2   (ifid_use_rs2),
    .idex_opcode    (idex_opcode),
    .idex_rd        (idex_rd),
    .ex_branch_taken(ex_branch_taken),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .pc_en          (pc_en),
    .ifid_flag      (ifid_flag),
    .idex_flag      (idex_flag),
    .exmem_flag     (exmem_flag),
    .pc_replace     (pc_replace),
    .stall_cycles   (stall_cycles),
    .mem_err        (mem_err)
  );

  assign outs = {pc_en, ifid_flag, idex_flag, exmem_flag, pc_replace};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input logic u1, input logic u2);
    idex_opcode  = op;
    idex_rd      = rd;
    ifid_rs1     = r1;
    ifid_rs2     = r2;
    ifid_use_rs1 = u1;
    ifid_use_rs2 = u2;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset = 1'b1;
    ex_branch_taken = 1'b0;
    mem_req = 1'b0;
    mem_ready = 1'b0;
    set_id(OP_ADD, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cyc();
    cyc();
    check("rst_outs", 32'(outs), 32'h0f);
    reset = 1'b0;
    #1;
    check("idle_outs", 32'(outs), 32'h1e);
    check("rst_stall", stall_cycles, 32'd0);
    check("rst_err", 32'(mem_err), 32'd0);

    // load-use on rs1
    set_id(OP_LW, 5'd5, 5'd5, 5'd1, 1'b1, 1'b1);
    #1;
    check("lu_rs1", 32'(outs), 32'h07);
    cyc();
    set_id(OP_ADD, 5'd5, 5'd5, 5'd1, 1'b1, 1'b1);
    #1;
    check("lu_after", 32'(outs), 32'h1e);
    check("lu_stall", stall_cycles, 32'd1);
    // rs2 match counts, rs1 match without use does not
    set_id(OP_LW, 5'd7, 5'd7, 5'd2, 1'b0, 1'b1);
    #1;
    check("lu_nouse", 32'(outs), 32'h1e);
    set_id(OP_LW, 5'd7, 5'd3, 5'd7, 1'b0, 1'b1);
    #1;
    check("lu_rs2", 32'(outs), 32'h07);
    cyc();
    set_id(OP_LW, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    #1;
    check("lu_x0", 32'(outs), 32'h1e);
    check("lu2_stall", stall_cycles, 32'd2);
    cyc();
    check("x0_stall", stall_cycles, 32'd2);

    // branch flush for two cycles, load-use ignored in FLUSH
    set_id(OP_ADD, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    ex_branch_taken = 1'b1;
    #1;
    check("br_c0", 32'(outs), 32'h1f);
    cyc();
    ex_branch_taken = 1'b0;
    set_id(OP_LW, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    #1;
    check("br_c1_lu", 32'(outs), 32'h1f);
    cyc();
    set_id(OP_ADD, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    check("br_c2", 32'(outs), 32'h1e);
    check("br_stall", stall_cycles, 32'd2);

    // second branch in FLUSH reloads the counter
    ex_branch_taken = 1'b1;
    cyc();
    #1;
    check("rl_c1", 32'(outs), 32'h1f);
    cyc();
    ex_branch_taken = 1'b0;
    #1;
    check("rl_c2", 32'(outs), 32'h1f);
    cyc();
    check("rl_c3", 32'(outs), 32'h1e);

    // memory wait of 3 cycles
    mem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("mw_%0d", i), 32'(outs), 32'h00);
      cyc();
    end
    mem_ready = 1'b1;
    #1;
    check("mw_rel", 32'(outs), 32'h1e);
    cyc();
    mem_req = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("mw_stall", stall_cycles, 32'd5);
    check("mw_err", 32'(mem_err), 32'd0);

    // timeout after 16 stall cycles
    mem_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      check($sformatf("to_%0d", i), 32'(outs), 32'h00);
      cyc();
    end
    #1;
    check("to_rel", 32'(outs), 32'h1e);
    check("to_err_pre", 32'(mem_err), 32'd0);
    cyc();
    mem_req = 1'b0;
    #1;
    check("to_err", 32'(mem_err), 32'd1);
    check("to_stall", stall_cycles, 32'd21);
    cyc();
    cyc();
    check("to_sticky", 32'(mem_err), 32'd1);

    // branch during MEM_WAIT kills on release then flushes
    mem_req = 1'b1;
    #1;
    check("bw_c0", 32'(outs), 32'h00);
    cyc();
    ex_branch_taken = 1'b1;
    #1;
    check("bw_c1", 32'(outs), 32'h00);
    cyc();
    ex_branch_taken = 1'b0;
    #1;
    check("bw_c2", 32'(outs), 32'h00);
    cyc();
    mem_ready = 1'b1;
    #1;
    check("bw_rel", 32'(outs), 32'h1f);
    cyc();
    mem_req = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("bw_fl", 32'(outs), 32'h1f);
    cyc();
    check("bw_run", 32'(outs), 32'h1e);
    check("bw_stall", stall_cycles, 32'd24);

    // memory stall inside FLUSH keeps the pending kill
    ex_branch_taken = 1'b1;
    cyc();
    ex_branch_taken = 1'b0;
    mem_req = 1'b1;
    #1;
    check("fm_stall", 32'(outs), 32'h00);
    cyc();
    mem_ready = 1'b1;
    #1;
    check("fm_rel", 32'(outs), 32'h1f);
    cyc();
    mem_req = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("fm_fl", 32'(outs), 32'h1f);
    cyc();
    check("fm_run", 32'(outs), 32'h1e);
    check("fm_cnt", stall_cycles, 32'd25);

    // reset mid-FLUSH returns to RUN with counters cleared
    ex_branch_taken = 1'b1;
    cyc();
    ex_branch_taken = 1'b0;
    reset = 1'b1;
    #1;
    check("rf_outs", 32'(outs), 32'h0f);
    cyc();
    reset = 1'b0;
    #1;
    check("rf_run", 32'(outs), 32'h1e);
    check("rf_stall", stall_cycles, 32'd0);
    check("rf_err", 32'(mem_err), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
